cnt_trigger_capture: RTL and testbench
======================================

// Module: cnt_trigger_capture
// PURPOSE
//  Downstream debug stage for the 32-bit free-running oscillator counter. Samples
//  cnt_in every clk1 cycle into a circular capture buffer. Fires a masked-compare
//  trigger, then records a programmable number of post-trigger samples and freezes.
//  Plays the frozen window back through a simple read port, oldest sample first,
//  and drives status LEDs.
// PARAMETERS
//  DW        32  sample width; matches counter width
//  AW        4   buffer address width; depth = 2**AW = 16
//  POST_W    4   width of post_cnt; post_cnt must be <= 2**AW-1
// PORTS
//  clk1        in   1    platform clock (internal oscillator)
//  rstn        in   1    asynchronous, active-low reset
//  cnt_in      in   DW   counter value to observe
//  arm         in   1    1-cycle pulse: start acquisition
//  trig_value  in   DW   compare value; quasi-static while armed
//  trig_mask   in   DW   1 = bit participates in compare
//  post_cnt    in   POST_W  samples written after the trigger sample
//  rd_en       in   1    read strobe, honoured only in DONE
//  rd_data     out  DW   sample read out
//  rd_valid    out  1    rd_data valid; 1 cycle after accepted rd_en
//  rd_last     out  1    with rd_valid: newest sample of the window
//  busy        out  1    state is ARMED or POST
//  triggered   out  1    sticky; set at trigger, cleared by arm or reset
//  done        out  1    state is DONE (buffer frozen)
//  led_status  out  4    {done, triggered, busy, heartbeat=cnt_in[DW-1]}
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=rd_ptr=0, post counter=0.
//   Outputs at reset: rd_data=0, rd_valid=0, rd_last=0, busy=0, triggered=0, done=0.
//  Sample stage: smp <= cnt_in each cycle (1-cycle latency). Compare on smp:
//   hit = ((smp ^ trig_value) & trig_mask) == 0. trig_mask=0 gives hit on the first sample.
//  FSM:
//   IDLE  --arm-->            ARMED
//   ARMED                     writes smp at wr_ptr each cycle, wr_ptr++ (wraps mod 2**AW).
//                             On hit: the trigger sample is written, triggered<=1,
//                             pcnt<=post_cnt.
//                             Next state is DONE if post_cnt==0, else POST.
//   POST                      writes smp each cycle and decrements pcnt.
//                             The write made when pcnt==1 is the last; then -> DONE.
//   DONE                      no writes; rd_ptr loaded with wr_ptr (oldest entry) on entry.
//  Read: in DONE, rd_en -> next cycle rd_data=buf[rd_ptr], rd_valid=1, rd_ptr++.
//   After 2**AW reads rd_last=1 on the final one, then rd_ptr wraps and reads repeat.
//   rd_en outside DONE is ignored (rd_valid stays 0).
//  Window: 2**AW entries ending post_cnt samples after the trigger.
//   If fewer than 2**AW samples were written, the unwritten entries read 0.
//   The buffer is cleared by reset only.
//  arm in ARMED/POST: ignored. arm in DONE: rearm -> ARMED; triggered<=0;
//   wr_ptr keeps its value.
//  arm and rd_en in the same DONE cycle: arm wins, no read.
//  rstn asserted mid-acquisition or mid-readout: immediate return to the reset state.
//  Width: pcnt is POST_W bits; pointers are AW bits and wrap silently. No overflow flags.
// STRUCTURE
//  Shared package cnt_dbg_pkg: state enum {IDLE,ARMED,POST,DONE}, DW/AW defaults,
//   LED bit index constants.
//  Sub-module cap_ram: 2**AW x DW simple dual-port RAM.
//   One write port, registered read port (1-cycle latency), reset-cleared contents
//   (maps to EBR or distributed RAM).
//  Top level holds: sample register, comparator, FSM, pointers, post counter.
// TESTING
//  1 cnt_in ramp from 0, mask=FFFFFFFF, value=0x20, post_cnt=3, arm
//    -> triggered once sample 0x20 is written; done 4 cycles after the trigger write.
//    -> 16 reads return 0x14..0x23; rd_last on 0x23.
//  2 post_cnt=0, value=0x08 -> DONE the cycle after the trigger write;
//    last read sample = 0x08; the 8 entries never written read 0.
//  3 mask=0 -> trigger on the first sample after arm.
//  4 mask=0x0000000F, value=0x5 on the ramp -> first hit at a sample with low nibble 5;
//    arm repeated while busy has no effect.
//  5 rstn low during POST and during readout -> all outputs 0 next edge, state IDLE;
//    rd_en with no arm -> rd_valid stays 0.
//  6 rearm from DONE with arm+rd_en together -> no rd_valid; triggered clears;
//    new capture succeeds; 20 reads show wrap to the oldest entry after rd_last.

Source files
------------

// File: rtl/cnt_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_dbg_pkg
//  Description : Shared types and constants for the counter debug capture
//                slice: FSM state encoding, default widths and LED bit
//                positions.
//  Revision    : 1.0  initial release
// ============================================================================
package cnt_dbg_pkg;

    // Default data/address/post-count widths.
    localparam int unsigned C_DW     = 32;
    localparam int unsigned C_AW     = 4;
    localparam int unsigned C_POST_W = 4;

    // Acquisition state machine encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit positions inside led_status.
    localparam int unsigned C_LED_HEARTBEAT = 0;
    localparam int unsigned C_LED_BUSY      = 1;
    localparam int unsigned C_LED_TRIG      = 2;
    localparam int unsigned C_LED_DONE      = 3;

endpackage
`default_nettype wire

// File: rtl/cnt_trigger_capture_cap_ram.sv
`default_nettype none
// ============================================================================
//  Module      : cap_ram
//  Description : 2**AW x DW simple dual-port capture RAM. One write port,
//                one registered read port (1-cycle latency). Contents and the
//                read register are cleared by the asynchronous reset.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk1   in   1    clock
//    rstn   in   1    asynchronous active-low reset
//    we     in   1    write enable
//    waddr  in   AW   write address
//    wdata  in   DW   write data
//    re     in   1    read enable (updates rdata on the next edge)
//    raddr  in   AW   read address
//    rdata  out  DW   registered read data
// ============================================================================
module cap_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk1,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cnt_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_trigger_capture
//  Description : Debug capture stage for the free-running oscillator counter.
//                Samples cnt_in every cycle into a circular buffer, fires a
//                masked-compare trigger, records post_cnt further samples,
//                freezes and plays the window back oldest sample first.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk1        in   1       platform clock
//    rstn        in   1       asynchronous active-low reset
//    cnt_in      in   DW      counter value to observe
//    arm         in   1       start acquisition (1-cycle pulse)
//    trig_value  in   DW      compare value
//    trig_mask   in   DW      1 = bit participates in compare
//    post_cnt    in   POST_W  samples written after the trigger sample
//    rd_en       in   1       read strobe, honoured only in DONE
//    rd_data     out  DW      sample read out
//    rd_valid    out  1       rd_data valid, 1 cycle after accepted rd_en
//    rd_last     out  1       newest sample of the window
//    busy        out  1       ARMED or POST
//    triggered   out  1       sticky trigger flag, cleared by arm/reset
//    done        out  1       buffer frozen
//    led_status  out  4       {done, triggered, busy, heartbeat}
// ============================================================================
module cnt_trigger_capture
    import cnt_dbg_pkg::*;
#(
    parameter int unsigned DW     = C_DW,
    parameter int unsigned AW     = C_AW,
    parameter int unsigned POST_W = C_POST_W
) (
    input  logic              clk1,
    input  logic              rstn,
    input  logic [DW-1:0]     cnt_in,
    input  logic              arm,
    input  logic [DW-1:0]     trig_value,
    input  logic [DW-1:0]     trig_mask,
    input  logic [POST_W-1:0] post_cnt,
    input  logic              rd_en,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [3:0]        led_status
);

    localparam logic [AW-1:0]     C_PTR_ONE  = AW'(1);
    localparam logic [POST_W-1:0] C_PCNT_ONE = POST_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [DW-1:0]     smp_q,       smp_d;
    logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [POST_W-1:0] pcnt_q,      pcnt_d;
    logic              triggered_q, triggered_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              rd_last_q,   rd_last_d;

    logic              w_hit;
    logic              w_wr_en;
    logic              w_rd_go;
    logic [DW-1:0]     w_ram_rdata;

    // Compare is made on the registered sample, i.e. the value being written.
    assign w_hit = (((smp_q ^ trig_value) & trig_mask) == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        smp_d       = cnt_in;
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pcnt_d      = pcnt_q;
        triggered_d = triggered_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_go     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end

            ARMED: begin
                w_wr_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                if (w_hit) begin
                    triggered_d = 1'b1;
                    pcnt_d      = post_cnt;
                    if (post_cnt == '0) begin
                        state_d  = DONE;
                        // Oldest entry is the slot after the final write.
                        rd_ptr_d = wr_ptr_q + C_PTR_ONE;
                    end else begin
                        state_d  = POST;
                    end
                end
            end

            POST: begin
                w_wr_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                pcnt_d   = pcnt_q - C_PCNT_ONE;
                if (pcnt_q == C_PCNT_ONE) begin
                    state_d  = DONE;
                    rd_ptr_d = wr_ptr_q + C_PTR_ONE;
                end
            end

            DONE: begin
                // A rearm takes priority over a coincident read strobe.
                if (arm) begin
                    state_d     = ARMED;
                    triggered_d = 1'b0;
                end else if (rd_en) begin
                    w_rd_go    = 1'b1;
                    rd_valid_d = 1'b1;
                    // Newest entry sits just before the frozen write pointer.
                    rd_last_d  = ((rd_ptr_q + C_PTR_ONE) == wr_ptr_q);
                    rd_ptr_d   = rd_ptr_q + C_PTR_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            smp_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pcnt_q      <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pcnt_q      <= pcnt_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture buffer
    // ------------------------------------------------------------------
    cap_ram #(
        .DW (DW),
        .AW (AW)
    ) u_cap_ram (
        .clk1  (clk1),
        .rstn  (rstn),
        .we    (w_wr_en),
        .waddr (wr_ptr_q),
        .wdata (smp_q),
        .re    (w_rd_go),
        .raddr (rd_ptr_q),
        .rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data   = w_ram_rdata;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q == ARMED) || (state_q == POST);
    assign done      = (state_q == DONE);
    assign triggered = triggered_q;

    assign led_status[C_LED_DONE]      = done;
    assign led_status[C_LED_TRIG]      = triggered;
    assign led_status[C_LED_BUSY]      = busy;
    assign led_status[C_LED_HEARTBEAT] = cnt_in[DW-1];

endmodule
`default_nettype wire

// File: tb/tb_cnt_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_trigger_capture
//  Description : Directed self-checking bench for cnt_trigger_capture.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnt_trigger_capture;

    logic        clk1 = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] cnt_in = '0;
    logic        arm = 1'b0;
    logic [31:0] trig_value = '0;
    logic [31:0] trig_mask = '0;
    logic [3:0]  post_cnt = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        busy;
    logic        triggered;
    logic        done;
    logic [3:0]  led_status;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_win [20];

    cnt_trigger_capture #(
        .DW     (32),
        .AW     (4),
        .POST_W (4)
    ) dut (
        .clk1       (clk1),
        .rstn       (rstn),
        .cnt_in     (cnt_in),
        .arm        (arm),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .post_cnt   (post_cnt),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .led_status (led_status)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the counter ramp advances just after every edge.
    task automatic tick();
        @(posedge clk1);
        #1;
        cnt_in = cnt_in + 32'd1;
    endtask

    task automatic do_reset();
        arm   = 1'b0;
        rd_en = 1'b0;
        rstn  = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        rstn  = 1'b1;
    endtask

    // Streams n reads and compares against exp_win; rd_last on every 16th.
    task automatic read_window(input string name, input int n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s_valid%0d", name, i), rd_valid, 1);
            check($sformatf("%s_data%0d", name, i), rd_data, exp_win[i]);
            check($sformatf("%s_last%0d", name, i), rd_last, ((i % 16) == 15) ? 1 : 0);
        end
        rd_en = 1'b0;
        tick();
        check($sformatf("%s_valid_end", name), rd_valid, 0);
    endtask

    initial begin
        // ---------------- Test 1: ramp, exact compare, post 3 ----------------
        do_reset();
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_busy", busy, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_led", led_status, 4'h0);

        trig_mask  = 32'hFFFF_FFFF;
        trig_value = 32'h20;
        post_cnt   = 4'd3;
        cnt_in     = 32'h0;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_led_busy", led_status, 4'h2);
        repeat (32) tick();
        check("t1_not_yet_trig", triggered, 0);
        tick();
        check("t1_trig", triggered, 1);
        check("t1_busy_post", busy, 1);
        tick();
        tick();
        check("t1_done_early", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_busy_off", busy, 0);
        check("t1_led_done", led_status, 4'hC);
        for (int i = 0; i < 16; i++) exp_win[i] = 32'h14 + i;
        read_window("t1", 16);

        // ---------------- Test 2: post 0, partially filled buffer -------------
        do_reset();
        trig_value = 32'h08;
        post_cnt   = 4'd0;
        cnt_in     = 32'h1;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        repeat (7) tick();
        check("t2_not_yet_trig", triggered, 0);
        tick();
        check("t2_trig", triggered, 1);
        check("t2_done", done, 1);
        for (int i = 0; i < 16; i++) exp_win[i] = (i < 8) ? 32'h0 : 32'(i - 7);
        read_window("t2", 16);

        // ---------------- Test 3: mask 0 triggers immediately -----------------
        do_reset();
        trig_mask  = 32'h0;
        trig_value = 32'hDEAD_BEEF;
        post_cnt   = 4'd2;
        cnt_in     = 32'h100;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        check("t3_trig_before", triggered, 0);
        tick();
        check("t3_trig", triggered, 1);
        tick();
        check("t3_done_early", done, 0);
        tick();
        check("t3_done", done, 1);
        for (int i = 0; i < 16; i++) exp_win[i] = (i < 13) ? 32'h0 : 32'h100 + 32'(i - 13);
        read_window("t3", 16);

        // ---------------- Test 4: nibble mask, arm while busy -----------------
        do_reset();
        trig_mask  = 32'h0000_000F;
        trig_value = 32'h5;
        post_cnt   = 4'd1;
        cnt_in     = 32'h30;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t4_arm_ignored_busy", busy, 1);
        check("t4_arm_ignored_trig", triggered, 0);
        tick();
        tick();
        check("t4_not_yet_trig", triggered, 0);
        tick();
        check("t4_trig", triggered, 1);
        check("t4_post_busy", busy, 1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t4_done", done, 1);
        check("t4_trig_kept", triggered, 1);
        for (int i = 0; i < 16; i++) exp_win[i] = (i < 9) ? 32'h0 : 32'h30 + 32'(i - 9);
        read_window("t4", 16);

        // ---------------- Test 6: rearm with coincident read ------------------
        trig_mask  = 32'hFFFF_FFFF;
        trig_value = 32'h208;
        post_cnt   = 4'd2;
        cnt_in     = 32'h200;
        arm        = 1'b1;
        rd_en      = 1'b1;
        tick();
        arm = 1'b0;
        check("t6_no_read", rd_valid, 0);
        check("t6_trig_clr", triggered, 0);
        check("t6_busy", busy, 1);
        tick();
        rd_en = 1'b0;
        check("t6_read_in_armed", rd_valid, 0);
        repeat (8) tick();
        check("t6_trig", triggered, 1);
        tick();
        tick();
        check("t6_done", done, 1);
        for (int i = 0; i < 5; i++) exp_win[i] = 32'h32 + i;
        for (int i = 5; i < 14; i++) exp_win[i] = 32'h200 + 32'(i - 5);
        exp_win[14] = 32'h209;
        exp_win[15] = 32'h20A;
        for (int i = 16; i < 20; i++) exp_win[i] = 32'h32 + 32'(i - 16);
        read_window("t6", 20);

        // ---------------- Test 5: reset mid-acquisition and mid-readout -------
        do_reset();
        trig_mask = 32'h0;
        post_cnt  = 4'd5;
        cnt_in    = 32'h400;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
        check("t5_in_post", busy, 1);
        rstn = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_trig", triggered, 0);
        check("t5_rst_done", done, 0);
        tick();
        check("t5_rst_edge_busy", busy, 0);
        rstn  = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_noarm_read%0d", i), rd_valid, 0);
        end
        check("t5_idle_done", done, 0);
        rd_en = 1'b0;

        post_cnt = 4'd1;
        cnt_in   = 32'h500;
        arm      = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
        check("t5b_done", done, 1);
        rd_en = 1'b1;
        repeat (15) tick();
        check("t5b_valid", rd_valid, 1);
        check("t5b_data", rd_data, 32'h500);
        rstn = 1'b0;
        #1;
        check("t5b_rst_valid", rd_valid, 0);
        check("t5b_rst_data", rd_data, 0);
        check("t5b_rst_done", done, 0);
        check("t5b_rst_trig", triggered, 0);
        tick();
        rstn = 1'b1;
        tick();
        check("t5b_idle_read", rd_valid, 0);
        check("t5b_idle_busy", busy, 0);
        rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
